// File: rtl/axis_pkt_rr_arbiter_if.sv
// Bus bundle for the packet round-robin arbiter: NUM_IN flattened source
// streams in, one arbitrated stream out, plus grant/status observation.
interface axis_pkt_rr_arbiter_if #(
  parameter int unsigned NUM_IN = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned KEEP_W = DATA_W / 8
);
  logic [NUM_IN*DATA_W-1:0] axis_tdata_in;
  logic [NUM_IN*KEEP_W-1:0] axis_tkeep_in;
  logic [NUM_IN-1:0]        axis_tvalid_in;
  logic [NUM_IN-1:0]        axis_tlast_in;
  logic [NUM_IN-1:0]        axis_tready_out;
  logic [DATA_W-1:0]        axis_tdata_out;
  logic [KEEP_W-1:0]        axis_tkeep_out;
  logic                     axis_tvalid_out;
  logic                     axis_tlast_out;
  logic                     axis_tready_in;
  logic [NUM_IN-1:0]        grant_onehot;
  logic                     busy;
  logic                     pkt_done;

  modport slave (
    input  axis_tdata_in, axis_tkeep_in, axis_tvalid_in, axis_tlast_in, axis_tready_in,
    output axis_tready_out, axis_tdata_out, axis_tkeep_out, axis_tvalid_out, axis_tlast_out,
    output grant_onehot, busy, pkt_done
  );

  modport master (
    output axis_tdata_in, axis_tkeep_in, axis_tvalid_in, axis_tlast_in, axis_tready_in,
    input  axis_tready_out, axis_tdata_out, axis_tkeep_out, axis_tvalid_out, axis_tlast_out,
    input  grant_onehot, busy, pkt_done
  );
endinterface

// File: rtl/axis_pkt_rr_arbiter.sv
// Packet-granular round-robin arbiter: shares one registered AXI-Stream output
// between NUM_IN sources without interleaving packets.
module axis_pkt_rr_arbiter #(
  parameter int unsigned NUM_IN = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned KEEP_W = DATA_W / 8
) (
  input  logic                 clk,
  input  logic                 reset,
  axis_pkt_rr_arbiter_if.slave bus
);
  localparam int unsigned IDX_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam int unsigned SCAN_W = IDX_W + 1;

  typedef enum logic {IDLE = 1'b0, PASS = 1'b1} state_e;

  state_e              state_q;
  logic [NUM_IN-1:0]   grant_q;
  logic [IDX_W-1:0]    gidx_q;
  logic [IDX_W-1:0]    rr_ptr_q;
  logic                busy_q;
  logic                pkt_done_q;
  logic                out_vld_q;
  logic                out_last_q;
  logic [DATA_W-1:0]   out_data_q;
  logic [KEEP_W-1:0]   out_keep_q;

  logic                ld;
  logic                acc;
  logic [NUM_IN-1:0]   ready_c;
  logic                sel_vld;
  logic                sel_last;
  logic [DATA_W-1:0]   sel_data;
  logic [KEEP_W-1:0]   sel_keep;
  logic                pick_vld;
  logic [IDX_W-1:0]    pick_idx;
  logic [SCAN_W-1:0]   scan_idx;

  // Output register can take a new beat when empty or being drained this cycle.
  assign ld      = ~out_vld_q | bus.axis_tready_in;
  assign ready_c = (state_q == PASS) ? (grant_q & {NUM_IN{ld}}) : '0;
  assign acc     = (state_q == PASS) & ld & sel_vld;

  // Granted-stream mux
  always_comb begin
    sel_vld  = 1'b0;
    sel_last = 1'b0;
    sel_data = '0;
    sel_keep = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      if (gidx_q == IDX_W'(i)) begin
        sel_vld  = bus.axis_tvalid_in[i];
        sel_last = bus.axis_tlast_in[i];
        sel_data = bus.axis_tdata_in[i*DATA_W +: DATA_W];
        sel_keep = bus.axis_tkeep_in[i*KEEP_W +: KEEP_W];
      end
    end
  end

  // First requester after rr_ptr, wrapping modulo NUM_IN
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    scan_idx = '0;
    for (int unsigned k = 1; k <= NUM_IN; k++) begin
      scan_idx = {1'b0, rr_ptr_q} + SCAN_W'(k);
      if (scan_idx >= SCAN_W'(NUM_IN)) scan_idx = scan_idx - SCAN_W'(NUM_IN);
      if (!pick_vld && bus.axis_tvalid_in[scan_idx[IDX_W-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = scan_idx[IDX_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      gidx_q     <= '0;
      rr_ptr_q   <= IDX_W'(NUM_IN - 1);
      busy_q     <= 1'b0;
      pkt_done_q <= 1'b0;
      out_vld_q  <= 1'b0;
      out_last_q <= 1'b0;
      out_data_q <= '0;
      out_keep_q <= '0;
    end else begin
      pkt_done_q <= 1'b0;
      if (ld) begin
        out_vld_q <= acc;
        if (acc) begin
          out_data_q <= sel_data;
          out_keep_q <= sel_keep;
          out_last_q <= sel_last;
        end
      end
      case (state_q)
        IDLE: begin
          if (pick_vld) begin
            grant_q <= NUM_IN'(1) << pick_idx;
            gidx_q  <= pick_idx;
            busy_q  <= 1'b1;
            state_q <= PASS;
          end
        end
        PASS: begin
          // Grant is released only once the tlast beat is taken.
          if (acc && sel_last) begin
            pkt_done_q <= 1'b1;
            rr_ptr_q   <= gidx_q;
            grant_q    <= '0;
            busy_q     <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.axis_tready_out = ready_c;
  assign bus.axis_tdata_out  = out_data_q;
  assign bus.axis_tkeep_out  = out_keep_q;
  assign bus.axis_tvalid_out = out_vld_q;
  assign bus.axis_tlast_out  = out_last_q;
  assign bus.grant_onehot    = grant_q;
  assign bus.busy            = busy_q;
  assign bus.pkt_done        = pkt_done_q;
endmodule

// File: tb/tb_axis_pkt_rr_arbiter.sv
// Bench for axis_pkt_rr_arbiter: per-source packet queues, a transaction-level
// arbitration model and scenario tasks with inline checks.
module tb_axis_pkt_rr_arbiter;
  localparam int unsigned NUM_IN = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned KEEP_W = DATA_W / 8;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic              last;
    logic [3:0]        gap;
  } beat_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  axis_pkt_rr_arbiter_if #(.NUM_IN(NUM_IN), .DATA_W(DATA_W), .KEEP_W(KEEP_W)) bus ();
  axis_pkt_rr_arbiter #(.NUM_IN(NUM_IN), .DATA_W(DATA_W), .KEEP_W(KEEP_W)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );

  beat_t             src_q[NUM_IN][$];
  beat_t             cur[NUM_IN];
  logic [NUM_IN-1:0] vld;
  int                gap_cnt[NUM_IN];
  int                ready_mode, pat_cnt, cyc;
  bit                m_pass, m_out_vld, m_done;
  int                m_g, m_ptr;
  beat_t             m_out;
  beat_t             exp_q[$], obs_q[$];
  int                obs_cyc[$];
  int                hs_err, acc_total, done_cnt, rdy0_cnt, vout_cnt;
  int                checks = 0, errors = 0;

  function automatic int pick(int ptr, logic [NUM_IN-1:0] req);
    for (int k = 1; k <= NUM_IN; k++)
      if (req[(ptr + k) % NUM_IN]) return (ptr + k) % NUM_IN;
    return 0;
  endfunction

  function automatic beat_t mk(int s, int seq, logic [KEEP_W-1:0] keep, logic last, int gap);
    beat_t b;
    b.data = {4'(s), 28'(seq)};
    b.keep = keep;
    b.last = last;
    b.gap  = 4'(gap);
    return b;
  endfunction

  function automatic bit pending();
    bit p = m_pass || m_out_vld || (vld != '0);
    for (int i = 0; i < NUM_IN; i++) if (src_q[i].size() > 0) p = 1'b1;
    return p;
  endfunction

  // One clock: drive sources, compare DUT against the model, advance the model.
  task automatic step();
    logic rdy, ld, acc;
    logic [NUM_IN-1:0] exp_rdy, exp_grant;
    beat_t b;
    @(negedge clk);
    cyc++;
    for (int i = 0; i < NUM_IN; i++) begin
      if (!vld[i] && src_q[i].size() > 0) begin
        if (gap_cnt[i] < int'(src_q[i][0].gap)) gap_cnt[i]++;
        else begin cur[i] = src_q[i].pop_front(); vld[i] = 1'b1; gap_cnt[i] = 0; end
      end
      bus.axis_tdata_in[i*DATA_W +: DATA_W] = vld[i] ? cur[i].data : '0;
      bus.axis_tkeep_in[i*KEEP_W +: KEEP_W] = vld[i] ? cur[i].keep : '0;
      bus.axis_tlast_in[i] = vld[i] & cur[i].last;
    end
    bus.axis_tvalid_in = vld;
    case (ready_mode)
      0:       rdy = 1'b1;
      1:       rdy = ($urandom_range(0, 3) != 0);
      default: rdy = (pat_cnt % 3 == 0);
    endcase
    pat_cnt++;
    bus.axis_tready_in = rdy;
    #1;
    ld        = !m_out_vld || rdy;
    exp_rdy   = (m_pass && ld) ? (NUM_IN'(1) << m_g) : '0;
    exp_grant = m_pass ? (NUM_IN'(1) << m_g) : '0;
    if (bus.axis_tvalid_out !== m_out_vld ||
        (m_out_vld && (bus.axis_tdata_out !== m_out.data || bus.axis_tkeep_out !== m_out.keep ||
                       bus.axis_tlast_out !== m_out.last)) ||
        bus.grant_onehot !== exp_grant || bus.busy !== m_pass ||
        bus.pkt_done !== m_done || bus.axis_tready_out !== exp_rdy) begin
      if (hs_err < 4)
        $display("  cycle %0d divergence (dut/model): vld %b/%b data %h/%h grant %b/%b busy %b/%b done %b/%b ready %b/%b",
                 cyc, bus.axis_tvalid_out, m_out_vld, bus.axis_tdata_out, m_out.data, bus.grant_onehot,
                 exp_grant, bus.busy, m_pass, bus.pkt_done, m_done, bus.axis_tready_out, exp_rdy);
      hs_err++;
    end
    if (bus.pkt_done === 1'b1) done_cnt++;
    if (bus.axis_tready_out[0] === 1'b1) rdy0_cnt++;
    if (bus.axis_tvalid_out === 1'b1) vout_cnt++;
    if (bus.axis_tvalid_out === 1'b1 && rdy) begin
      b.data = bus.axis_tdata_out; b.keep = bus.axis_tkeep_out; b.last = bus.axis_tlast_out; b.gap = '0;
      obs_q.push_back(b);
      obs_cyc.push_back(cyc);
    end
    if (m_out_vld && rdy) exp_q.push_back(m_out);
    acc    = m_pass && ld && vld[m_g];
    m_done = 1'b0;
    if (acc) begin m_out = cur[m_g]; m_out.gap = '0; vld[m_g] = 1'b0; acc_total++; end
    if (ld) m_out_vld = acc;
    if (m_pass) begin
      if (acc && m_out.last) begin m_done = 1'b1; m_ptr = m_g; m_pass = 1'b0; end
    end else if (vld != '0) begin
      m_g = pick(m_ptr, vld);
      m_pass = 1'b1;
    end
  endtask

  task automatic drain(string name);
    int n = 0;
    while (pending() && n < 3000) begin step(); n++; end
    step(); step();
    checks++;
    if (pending()) begin
      errors++;
      $display("FAIL %s_timeout: traffic still pending after %0d cycles, required drained", name, n);
    end
  endtask

  task automatic clear_obs();
    obs_q.delete(); obs_cyc.delete(); exp_q.delete();
    hs_err = 0; done_cnt = 0; rdy0_cnt = 0; vout_cnt = 0; acc_total = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    vld = '0;
    for (int i = 0; i < NUM_IN; i++) begin src_q[i].delete(); gap_cnt[i] = 0; end
    bus.axis_tvalid_in = '0; bus.axis_tdata_in = '0; bus.axis_tkeep_in = '0;
    bus.axis_tlast_in = '0; bus.axis_tready_in = 1'b1;
    @(posedge clk); #1;
    m_pass = 1'b0; m_g = 0; m_ptr = NUM_IN - 1; m_out_vld = 1'b0; m_out = '0; m_done = 1'b0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (bus.axis_tvalid_out !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b, required 0", bus.axis_tvalid_out); end
    checks++; if (bus.grant_onehot !== '0) begin errors++; $display("FAIL reset_grant: got %b, required 0", bus.grant_onehot); end
    checks++; if (bus.busy !== 1'b0 || bus.pkt_done !== 1'b0) begin errors++; $display("FAIL reset_status: busy %b done %b, required 0 0", bus.busy, bus.pkt_done); end
    checks++; if (bus.axis_tready_out !== '0) begin errors++; $display("FAIL reset_ready: got %b, required 0", bus.axis_tready_out); end
    checks++; if ({bus.axis_tdata_out, bus.axis_tkeep_out, bus.axis_tlast_out} !== '0) begin errors++; $display("FAIL reset_data: got %h/%h/%b, required zeros", bus.axis_tdata_out, bus.axis_tkeep_out, bus.axis_tlast_out); end
    release_reset();
  endtask

  task automatic test_single_beat();
    beat_t b;
    clear_obs(); ready_mode = 0;
    b.data = 32'hA5A5_0001; b.keep = 4'hF; b.last = 1'b1; b.gap = '0;
    src_q[0].push_back(b);
    drain("single");
    checks++; if (hs_err !== 0) begin errors++; $display("FAIL single_cycle_model: %0d diverging cycles, required 0", hs_err); end
    checks++; if (obs_q.size() !== 1 || obs_q[0].data !== 32'hA5A5_0001 || obs_q[0].keep !== 4'hF || obs_q[0].last !== 1'b1) begin
      errors++; $display("FAIL single_beat_out: %0d beats first %h, required 1 beat a5a50001/f/1", obs_q.size(), obs_q.size() > 0 ? obs_q[0].data : 32'h0); end
    checks++; if (rdy0_cnt !== 1 || vout_cnt !== 1 || done_cnt !== 1) begin
      errors++; $display("FAIL single_pulses: ready %0d valid %0d done %0d cycles, required 1 1 1", rdy0_cnt, vout_cnt, done_cnt); end
    checks++; if (bus.grant_onehot !== '0) begin errors++; $display("FAIL single_grant_release: got %b, required 0", bus.grant_onehot); end
  endtask

  task automatic test_round_robin();
    apply_reset(); release_reset();
    clear_obs(); ready_mode = 0;
    for (int s = 0; s < NUM_IN; s++)
      for (int bt = 1; bt <= 3; bt++) src_q[s].push_back(mk(s, bt, 4'hF, bt == 3, 0));
    drain("round_robin");
    checks++; if (hs_err !== 0) begin errors++; $display("FAIL rr_cycle_model: %0d diverging cycles, required 0", hs_err); end
    checks++;
    if (obs_q.size() !== 12) begin errors++; $display("FAIL rr_beat_count: got %0d, required 12", obs_q.size()); end
    else begin
      int bad = 0;
      for (int k = 0; k < 12; k++)
        if (obs_q[k].data !== {4'(k / 3), 28'(k % 3 + 1)} || obs_q[k].last !== (k % 3 == 2)) bad++;
      if (bad != 0) begin errors++; $display("FAIL rr_order: %0d beats out of order, required 0", bad); end
      checks++;
      if (obs_cyc[11] - obs_cyc[0] !== 14) begin errors++; $display("FAIL rr_bubble_span: %0d cycles, required 14", obs_cyc[11] - obs_cyc[0]); end
    end
  endtask

  task automatic test_fairness();
    int exp_tag[6] = '{1, 0, 1, 1, 3, 1};
    clear_obs(); ready_mode = 0;
    for (int r = 0; r < 2; r++) begin
      src_q[1].push_back(mk(1, 0, 4'hF, 1'b1, 0));
      drain("fair_solo");
      src_q[r == 0 ? 0 : 3].push_back(mk(r == 0 ? 0 : 3, 1, 4'hF, 1'b1, 0));
      src_q[1].push_back(mk(1, 1, 4'hF, 1'b1, 0));
      drain("fair_pair");
    end
    checks++; if (hs_err !== 0) begin errors++; $display("FAIL fair_cycle_model: %0d diverging cycles, required 0", hs_err); end
    checks++;
    if (obs_q.size() !== 6) begin errors++; $display("FAIL fair_count: got %0d, required 6", obs_q.size()); end
    else for (int k = 0; k < 6; k++) begin
      checks++;
      if (int'(obs_q[k].data[31:28]) !== exp_tag[k]) begin
        errors++; $display("FAIL fair_winner_%0d: stream %0d, required %0d", k, obs_q[k].data[31:28], exp_tag[k]); end
    end
  endtask

  task automatic test_backpressure();
    beat_t sent[$];
    clear_obs(); ready_mode = 2; pat_cnt = 0;
    for (int bt = 0; bt < 5; bt++) begin
      beat_t b = mk(2, bt, (bt == 4) ? 4'h3 : 4'hF, bt == 4, 0);
      b.data[27:0] = 28'($urandom);
      sent.push_back(b); src_q[2].push_back(b);
    end
    drain("backpressure");
    ready_mode = 0;
    checks++; if (hs_err !== 0) begin errors++; $display("FAIL bp_stall_model: %0d diverging cycles, required 0", hs_err); end
    checks++;
    if (obs_q.size() !== 5) begin errors++; $display("FAIL bp_count: got %0d beats, required 5", obs_q.size()); end
    else for (int k = 0; k < 5; k++) begin
      checks++;
      if (obs_q[k].data !== sent[k].data || obs_q[k].keep !== sent[k].keep || obs_q[k].last !== sent[k].last) begin
        errors++; $display("FAIL bp_beat_%0d: got %h/%h/%b, required %h/%h/%b", k, obs_q[k].data, obs_q[k].keep,
                           obs_q[k].last, sent[k].data, sent[k].keep, sent[k].last); end
    end
  endtask

  task automatic test_source_gap();
    clear_obs(); ready_mode = 0;
    for (int bt = 0; bt < 4; bt++) src_q[0].push_back(mk(0, bt, 4'hF, bt == 3, (bt == 2) ? 4 : 0));
    for (int bt = 0; bt < 2; bt++) src_q[1].push_back(mk(1, bt, 4'hF, bt == 1, 0));
    drain("source_gap");
    checks++; if (hs_err !== 0) begin errors++; $display("FAIL gap_cycle_model: %0d diverging cycles, required 0", hs_err); end
    checks++;
    if (obs_q.size() !== 6) begin errors++; $display("FAIL gap_count: got %0d beats, required 6", obs_q.size()); end
    else for (int k = 0; k < 6; k++) begin
      checks++;
      if (obs_q[k].data !== {4'(k < 4 ? 0 : 1), 28'(k < 4 ? k : k - 4)}) begin
        errors++; $display("FAIL gap_beat_%0d: got %h, required stream %0d", k, obs_q[k].data, k < 4 ? 0 : 1); end
    end
  endtask

  task automatic test_reset_mid_packet();
    int n = 0;
    clear_obs(); ready_mode = 0;
    for (int bt = 0; bt < 4; bt++) src_q[0].push_back(mk(0, bt, 4'hF, bt == 3, 0));
    while (acc_total < 1 && n < 50) begin step(); n++; end
    checks++; if (acc_total !== 1) begin errors++; $display("FAIL rstmid_setup: %0d beats accepted, required 1", acc_total); end
    apply_reset();
    checks++;
    if ({bus.axis_tvalid_out, bus.axis_tlast_out, bus.axis_tkeep_out, bus.axis_tdata_out, bus.grant_onehot,
         bus.busy, bus.pkt_done, bus.axis_tready_out} !== '0) begin
      errors++; $display("FAIL rstmid_outputs: vld %b data %h grant %b busy %b ready %b, required all 0",
                         bus.axis_tvalid_out, bus.axis_tdata_out, bus.grant_onehot, bus.busy, bus.axis_tready_out); end
    release_reset();
    clear_obs();
    src_q[3].push_back(mk(3, 7, 4'hF, 1'b1, 0));
    src_q[0].push_back(mk(0, 7, 4'hF, 1'b1, 0));
    drain("reset_mid");
    checks++; if (hs_err !== 0) begin errors++; $display("FAIL rstmid_cycle_model: %0d diverging cycles, required 0", hs_err); end
    checks++;
    if (obs_q.size() !== 2 || obs_q[0].data[31:28] !== 4'd0 || obs_q[1].data[31:28] !== 4'd3) begin
      errors++; $display("FAIL rstmid_priority: %0d beats first stream %0d, required 2 beats stream 0 then 3",
                         obs_q.size(), obs_q.size() > 0 ? obs_q[0].data[31:28] : 4'hF); end
  endtask

  task automatic test_random();
    clear_obs(); ready_mode = 1;
    for (int p = 0; p < 40; p++) begin
      int s = $urandom_range(0, NUM_IN - 1);
      int len = $urandom_range(1, 4);
      for (int bt = 0; bt < len; bt++) begin
        beat_t b;
        b.data = $urandom; b.keep = KEEP_W'($urandom); b.last = (bt == len - 1);
        b.gap = 4'($urandom_range(0, 2));
        src_q[s].push_back(b);
      end
    end
    drain("random");
    ready_mode = 0;
    checks++; if (hs_err !== 0) begin errors++; $display("FAIL rand_cycle_model: %0d diverging cycles, required 0", hs_err); end
    checks++;
    if (obs_q.size() !== exp_q.size() || obs_q.size() == 0) begin
      errors++; $display("FAIL rand_count: got %0d beats, required %0d", obs_q.size(), exp_q.size()); end
    else for (int k = 0; k < obs_q.size(); k++) begin
      checks++;
      if (obs_q[k].data !== exp_q[k].data || obs_q[k].keep !== exp_q[k].keep || obs_q[k].last !== exp_q[k].last) begin
        errors++; $display("FAIL rand_beat_%0d: got %h/%h/%b, required %h/%h/%b", k, obs_q[k].data, obs_q[k].keep,
                           obs_q[k].last, exp_q[k].data, exp_q[k].keep, exp_q[k].last); end
    end
  endtask

  initial begin
    reset = 1'b1;
    vld = '0; ready_mode = 0; pat_cnt = 0; cyc = 0;
    m_pass = 1'b0; m_g = 0; m_ptr = NUM_IN - 1; m_out_vld = 1'b0; m_out = '0; m_done = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin cur[i] = '0; gap_cnt[i] = 0; end
    bus.axis_tvalid_in = '0; bus.axis_tdata_in = '0; bus.axis_tkeep_in = '0;
    bus.axis_tlast_in = '0; bus.axis_tready_in = 1'b1;
    clear_obs();
    test_reset();
    test_single_beat();
    test_round_robin();
    test_fairness();
    test_backpressure();
    test_source_gap();
    test_reset_mid_packet();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/axis_pkt_rr_arbiter.md
Name: axis_pkt_rr_arbiter

Overview:
- Packet-granular round-robin arbiter that shares one 32-bit AXI-Stream output between NUM_IN 32-bit AXI-Stream sources, e.g. several 8-to-32 width-converter outputs feeding the single UDP TX path.
- A packet, once granted, is never interleaved or pre-empted; the grant is released only after its tlast beat is accepted.
- Output is registered in a single stage that sustains 1 beat/cycle.

Parameters:
- NUM_IN, 4, number of requesting streams (2..8).
- DATA_W, 32, tdata width per stream (multiple of 8).
- KEEP_W, DATA_W/8, tkeep width per stream.

Ports:
- clk  input  1  single clock for all logic.
- reset  input  1  synchronous, active-high reset.
- axis_tdata_in  input  NUM_IN*DATA_W  flattened input data; stream i occupies [i*DATA_W +: DATA_W].
- axis_tkeep_in  input  NUM_IN*KEEP_W  flattened input byte enables.
- axis_tvalid_in  input  NUM_IN  per-stream valid.
- axis_tlast_in  input  NUM_IN  per-stream end of packet.
- axis_tready_out  output  NUM_IN  per-stream ready.
- axis_tdata_out  output  DATA_W  arbitrated data.
- axis_tkeep_out  output  KEEP_W  arbitrated byte enables.
- axis_tvalid_out  output  1  output valid.
- axis_tlast_out  output  1  output end of packet.
- axis_tready_in  input  1  downstream ready.
- grant_onehot  output  NUM_IN  current grant; 0 when no grant.
- busy  output  1  high while in the PASS state.
- pkt_done  output  1  one-cycle pulse when a granted stream's tlast beat is accepted.

Behaviour:
- Reset (clk edge with reset=1):
  - State goes to IDLE.
  - Outputs cleared: grant_onehot=0, busy=0, pkt_done=0, axis_tready_out=0, axis_tvalid_out=0, axis_tlast_out=0, axis_tkeep_out=0, axis_tdata_out=0.
  - rr_ptr=NUM_IN-1, so stream 0 has top priority first.
  - Reset mid-packet discards the output register contents and the grant; no recovery of the partial packet.
- Output register (out_vld/data/keep/last):
  - Load enable ld = ~out_vld | axis_tready_in.
  - On a cycle with ld=1: if a beat is accepted, the register captures it; otherwise out_vld <= 0.
  - Register holds while axis_tvalid_out=1 and axis_tready_in=0. Data, keep and last must stay stable while stalled.
- FSM IDLE:
  - axis_tready_out=0.
  - If any axis_tvalid_in is high, select the first requesting index scanning rr_ptr+1, rr_ptr+2, … modulo NUM_IN.
  - Register grant_onehot, set busy, and go to PASS the next cycle.
  - If no requests, stay in IDLE.
- FSM PASS, granted stream g:
  - axis_tready_out[g] = ld; all other ready bits are 0.
  - A beat is accepted when axis_tvalid_in[g] & axis_tready_out[g]; it appears on the outputs on the next cycle (1-cycle latency).
  - If g drops tvalid mid-packet, the grant is held indefinitely (no timeout).
  - On the accepted beat with tlast=1: pkt_done=1 on the next cycle, rr_ptr<=g, grant_onehot<=0, busy<=0, next state IDLE.
- Arbitration gap:
  - Tlast accepted in cycle N → IDLE in N+1 (arbitrate) → first beat of the next packet accepted no earlier than N+2.
  - Output bubble is exactly 1 cycle when downstream never stalls.
- Simultaneous requests are resolved purely by rr_ptr. A stream that just finished is lowest priority next time.
- A single-beat packet (tvalid & tlast on the first beat) is legal: PASS lasts one accept cycle.
- tkeep is passed through unmodified; no checks on its value.
- Requests asserted while another packet is in PASS are not sampled until IDLE; AXIS sources must hold tvalid.

Test Plan:
- Single-source single-beat packet: reset, stream 0 sends tdata=0xA5A5_0001, tkeep=0xF, tlast=1, downstream ready → tready_out[0] high for 1 cycle; axis_tvalid_out pulses with that data 1 cycle after accept; pkt_done pulses; grant returns to 0.
- Round robin across all streams: streams 0..3 each send a 3-beat packet (tdata=0x{i}000_000{beat}), all valid from the same cycle → output packet order 0,1,2,3; 1-cycle bubble between packets; 12 beats total, no interleaving.
- Fairness after a win: stream 1 finishes, then streams 0 and 1 both request → stream 2 is absent, so stream 0 wins. Repeat with 1 and 3 requesting after 1 finishes → 3 wins.
- Backpressure: a 5-beat packet on stream 2 with axis_tready_in toggling 1,0,0,1,… → no beat lost or duplicated; output stable while stalled; the tlast beat carries tkeep=0x3 unchanged.
- Source gap mid-packet: stream 0 drops tvalid for 4 cycles between beats 2 and 3 while stream 1 requests → grant stays on 0 until its tlast; stream 1 is granted only after.
- Reset mid-packet: assert reset during beat 2 of 4 → next cycle all outputs are 0 and the state is IDLE. After release, stream 0 has priority over stream 3 when both request.
